button_pulse_conditioner: RTL and testbench

//   Turns the two raw shift push-buttons into clean single-cycle shift_left/shift_right strobes for programmable_blinker.
//   Per button: synchroniser, debouncer, press one-pulse, and hold-to-auto-repeat.

---
 rtl/blinker_pkg.sv | 23 ++
 rtl/button_channel.sv | 120 ++++++++++++
 rtl/button_pulse_conditioner.sv | 64 ++++++
 tb/tb_button_pulse_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// Shared definitions for the blinker push-button front end: per-channel FSM
// state encoding, default debounce/repeat timing and button channel indices.
package blinker_pkg;

    // Per-button press state. IDLE means the debounced level is low.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Default timing, all in sample strobes.
    localparam int DEF_DB_SAMPLES     = 4;
    localparam int DEF_HOLD_SAMPLES   = 16;
    localparam int DEF_REPEAT_SAMPLES = 8;
    localparam int DEF_CNT_W          = 5;

    // Channel indices inside the per-button vectors.
    localparam int NUM_BTNS  = 2;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;

endpackage : blinker_pkg

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, sample-strobe debouncer and
// the IDLE/HELD/REPEAT press FSM. pulse_raw is combinational and only ever
// high on a sample_en cycle; the top level registers it after arbitration.
module button_channel
    import blinker_pkg::*;
#(
    parameter int DB_SAMPLES     = DEF_DB_SAMPLES,
    parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
    parameter int REPEAT_SAMPLES = DEF_REPEAT_SAMPLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_raw,
    output logic pulse_raw
);

    // Terminal values: a counter holding *_LAST on a sample means this
    // sample is the N-th one, so the event fires and the counter clears.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_SAMPLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_SAMPLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_SAMPLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_level_q, db_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Synchroniser runs every clock; debounce advances only on the strobe.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        if (sample_en) begin
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_d = ~db_level_q;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                // Any agreeing sample restarts the run, so short glitches vanish.
                db_cnt_d = '0;
            end
        end
    end

    // Press FSM; it looks at the level this sample produces so the press
    // pulse lines up with the debounce flip rather than a sample later.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pulse_raw  = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (db_level_d) begin
                        state_d    = HELD;
                        hold_cnt_d = '0;
                        pulse_raw  = 1'b1;
                    end
                end
                HELD: begin
                    // Release wins over a count expiring on the same sample.
                    if (!db_level_d) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = REPEAT;
                        hold_cnt_d = '0;
                        pulse_raw  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!db_level_d) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == REPEAT_LAST) begin
                        hold_cnt_d = '0;
                        pulse_raw  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Channel state registers; reset clears the synchroniser too, so a button
    // held through reset is re-seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule : button_channel

// File: rtl/button_pulse_conditioner.sv
// Two button channels feeding registered, mutually exclusive shift strobes
// for programmable_blinker. A coincident left+right pulse is dropped on both
// outputs; the channel FSMs never see the arbitration result.
module button_pulse_conditioner
    import blinker_pkg::*;
#(
    parameter int DB_SAMPLES     = DEF_DB_SAMPLES,
    parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES,
    parameter int REPEAT_SAMPLES = DEF_REPEAT_SAMPLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic shift_left,
    output logic shift_right
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] pulse_raw;
    logic                shift_left_q, shift_left_d;
    logic                shift_right_q, shift_right_d;

    assign btn_raw[BTN_LEFT]  = btn_left_raw;
    assign btn_raw[BTN_RIGHT] = btn_right_raw;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        button_channel #(
            .DB_SAMPLES     (DB_SAMPLES),
            .HOLD_SAMPLES   (HOLD_SAMPLES),
            .REPEAT_SAMPLES (REPEAT_SAMPLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .btn_raw   (btn_raw[i]),
            .pulse_raw (pulse_raw[i])
        );
    end

    // Arbitration: never present both shifts in the same cycle.
    always_comb begin
        shift_left_d  = pulse_raw[BTN_LEFT]  & ~pulse_raw[BTN_RIGHT];
        shift_right_d = pulse_raw[BTN_RIGHT] & ~pulse_raw[BTN_LEFT];
    end

    // Output registers give clean one-clock strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_left_q  <= 1'b0;
            shift_right_q <= 1'b0;
        end else begin
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
        end
    end

    assign shift_left  = shift_left_q;
    assign shift_right = shift_right_q;

endmodule : button_pulse_conditioner

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: directed button scenarios with a
// sample-level behavioural model checked every clock, plus literal pulse
// counts and spacings for each scenario.
module tb_button_pulse_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic rst;
    logic sample_en;
    logic btn_left_raw;
    logic btn_right_raw;
    logic shift_left;
    logic shift_right;

    always #5 clk = ~clk;

    button_pulse_conditioner dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .shift_left    (shift_left),
        .shift_right   (shift_right)
    );

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    // Model state: two-deep sync delay, debounced level with run length of
    // disagreeing samples, and "samples since press" for each button.
    int s1[2], s2[2], lvl[2], run[2], pressed[2], age[2];
    int expL = 0, expR = 0;

    int pl_t[256], pr_t[256];
    int nl = 0, nr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Predict the outputs after the coming posedge from the inputs now stable.
    task automatic model_step();
        int raw[2];
        int pul[2];
        raw[0] = int'(btn_left_raw);
        raw[1] = int'(btn_right_raw);
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                s1[c] = 0; s2[c] = 0; lvl[c] = 0; run[c] = 0; pressed[c] = 0; age[c] = 0;
            end
            expL = 0;
            expR = 0;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            pul[c] = 0;
            if (sample_en) begin
                if (s2[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == DB) begin
                        lvl[c] = 1 - lvl[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
                if (lvl[c] == 1 && pressed[c] == 0) begin
                    pressed[c] = 1;
                    age[c]     = 0;
                    pul[c]     = 1;
                end else if (pressed[c] == 1 && lvl[c] == 0) begin
                    pressed[c] = 0;
                end else if (pressed[c] == 1) begin
                    age[c]++;
                    if (age[c] == HOLD || (age[c] > HOLD && (age[c] - HOLD) % REP == 0))
                        pul[c] = 1;
                end
            end
            s2[c] = s1[c];
            s1[c] = raw[c];
        end
        expL = (pul[0] == 1 && pul[1] == 0) ? 1 : 0;
        expR = (pul[1] == 1 && pul[0] == 0) ? 1 : 0;
    endtask

    // One clock: compare at negedge, advance model, then drive after posedge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            ncyc++;
            chk("shift_left", int'(shift_left), expL);
            chk("shift_right", int'(shift_right), expR);
            if (shift_left === 1'b1) begin
                if (nl < 256) pl_t[nl] = ncyc;
                nl++;
            end
            if (shift_right === 1'b1) begin
                if (nr < 256) pr_t[nr] = ncyc;
                nr++;
            end
            model_step();
            @(posedge clk);
            #2;
            sample_en = ~sample_en;
        end
    endtask

    task automatic gaps(input string nm, input int b, input int right_ch);
        int t[5];
        for (int k = 0; k < 5; k++) t[k] = right_ch ? pr_t[(b + k) % 256] : pl_t[(b + k) % 256];
        chk({nm, "_hold_gap"}, t[1] - t[0], 2 * HOLD);
        chk({nm, "_rep_gap1"}, t[2] - t[1], 2 * REP);
        chk({nm, "_rep_gap2"}, t[3] - t[2], 2 * REP);
        chk({nm, "_rep_gap3"}, t[4] - t[3], 2 * REP);
    endtask

    initial begin
        int bl, br, b2;
        for (int c = 0; c < 2; c++) begin
            s1[c] = 0; s2[c] = 0; lvl[c] = 0; run[c] = 0; pressed[c] = 0; age[c] = 0;
        end
        rst           = 1'b1;
        sample_en     = 1'b0;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;

        // 1: reset with buttons low, then idle
        step(10);
        rst = 1'b0;
        step(20);
        chk("t1_left_cnt", nl, 0);
        chk("t1_right_cnt", nr, 0);

        // 2: bouncing press settles into a single pulse
        bl = nl;
        btn_left_raw = 1'b1; step(2);
        btn_left_raw = 1'b0; step(2);
        btn_left_raw = 1'b1; step(22);
        btn_left_raw = 1'b0; step(24);
        chk("t2_left_cnt", nl - bl, 1);
        chk("t2_right_cnt", nr, 0);

        // 3: long hold -> press, hold pulse, three repeats
        bl = nl;
        btn_left_raw = 1'b1; step(88);
        btn_left_raw = 1'b0; step(24);
        chk("t3_left_cnt", nl - bl, 5);
        gaps("t3", bl, 0);

        // 4: simultaneous press dropped; right then repeats alone
        bl = nl; br = nr;
        btn_left_raw = 1'b1; btn_right_raw = 1'b1; step(20);
        btn_left_raw = 1'b0; step(36);
        btn_right_raw = 1'b0; step(24);
        chk("t4_left_cnt", nl - bl, 0);
        chk("t4_right_cnt", nr - br, 2);
        chk("t4_right_gap", pr_t[(br + 1) % 256] - pr_t[br % 256], 2 * REP);

        // 5: short drop during REPEAT leaves cadence intact
        bl = nl; br = nr;
        btn_right_raw = 1'b1; step(52);
        btn_right_raw = 1'b0; step(4);
        btn_right_raw = 1'b1; step(32);
        btn_right_raw = 1'b0; step(24);
        chk("t5_right_cnt", nr - br, 5);
        chk("t5_left_cnt", nl - bl, 0);
        gaps("t5", br, 1);

        // 6: reset mid-REPEAT with left held, then the schedule restarts
        bl = nl;
        btn_left_raw = 1'b1; step(48);
        chk("t6_pre_rst_cnt", nl - bl, 2);
        rst = 1'b1; step(1);
        b2 = nl;
        step(1);
        rst = 1'b0; step(1);
        chk("t6_rst_window_cnt", nl - b2, 0);
        bl = nl;
        step(56);
        btn_left_raw = 1'b0; step(24);
        chk("t6_post_cnt", nl - bl, 3);
        chk("t6_hold_gap", pl_t[(bl + 1) % 256] - pl_t[bl % 256], 2 * HOLD);
        chk("t6_rep_gap", pl_t[(bl + 2) % 256] - pl_t[(bl + 1) % 256], 2 * REP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_button_pulse_conditioner
